hps_spi_bridge: RTL and testbench
=================================

Name: hps_spi_bridge

Overview:
Parametrised second-generation HPS link. Synchronises the HPS SPI and enable lines into sys_clk and runs its own SPI mode-0 shift engine with configurable word width. Received words go into an RX FIFO with a valid/ready handshake and overrun tracking. Sits between the HPS pins and the core's I/O decoder; gp_out, io_strobe and the enable bits serve the existing consumers.

Parameters:
WORD_W, 16, SPI word width in bits (8..24)
NUM_EN, 3, number of HPS enable lines synchronised (fpga/osd/io = bits 0/1/2)
SYNC_STAGES, 2, synchroniser flops per input (2..4)
FIFO_DEPTH, 4, RX FIFO entries; power of 2, at least 2

Ports:
sys_clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
spi_clk  in  1  HPS SPI clock, async, idle low
spi_cs  in  1  HPS chip select, async, active-low
spi_mosi  in  1  HPS data to FPGA, async
spi_miso  out  1  FPGA data to HPS
hps_en  in  NUM_EN  HPS enable lines, async
tx_word  in  WORD_W  word returned to HPS; sampled at each word start
rx_data  out  WORD_W  FIFO head word
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer pops head when rx_valid & rx_ready
clr_overrun  in  1  one-cycle pulse clears the overrun flag
io_strobe  out  1  one-cycle pulse per completed word
gp_out  out  WORD_W+NUM_EN+2  {en_sync, overrun, fifo_full, last_rx_word}

Behaviour:
- Reset (async assert, sync release): all synchroniser flops 0, except the cs chain at 1. bit_cnt=0, shift regs 0, FIFO empty, overrun=0. Outputs: spi_miso=0, rx_valid=0, rx_data=0, io_strobe=0, gp_out=0.
- Synchronisers: SYNC_STAGES flops on spi_clk, spi_cs, spi_mosi and each hps_en bit. One more flop on synced sck/cs gives edge detect: sck_rise, sck_fall, cs_fall, cs_rise.
- Engine states: IDLE and SHIFT.
  - IDLE to SHIFT on cs_fall: bit_cnt=0; tx_shift loads tx_word.
  - In SHIFT, sck_rise shifts the synced mosi into rx_shift LSB (MSB-first) and increments bit_cnt.
  - In SHIFT, sck_fall shifts tx_shift left. spi_miso = tx_shift MSB while cs is low, else 0.
  - When bit_cnt reaches WORD_W on a sck_rise, the word completes: rx_shift (including this bit) goes to FIFO push, bit_cnt wraps to 0, and tx_shift reloads from tx_word. Back-to-back words within one frame are supported.
  - cs_rise in any state: back to IDLE, partial word discarded, no push, no strobe.
  - cs_fall while already in SHIFT (glitch): restarts at bit 0.
- Latency: synced final sck_rise detected in cycle t. Push and last_rx_word update at end of t+1. rx_valid, io_strobe and gp_out reflect the word in cycle t+2. io_strobe is exactly one cycle wide.
- FIFO: push accepted if not full, or if a pop happens in the same cycle. Otherwise the word is dropped and overrun sets (sticky). Simultaneous push and pop when empty: push wins, rx_valid rises next cycle. Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- overrun: clr_overrun clears it. If clear and a new drop occur in the same cycle, overrun stays set.
- io_strobe pulses on every completed word, even when the word is dropped.
- gp_out is registered every cycle. last_rx_word updates on every completed word regardless of FIFO state.

Decomposition:
- hps_bridge_pkg holds the gp_out field offsets (LAST_LSB, FULL_BIT, OVR_BIT, EN_LSB) and the engine state encoding.
- One sub-module, hps_spi_shift_engine (synced sck/cs/mosi plus tx_word in; word + word_done pulse out). FIFO, synchronisers and gp_out packing stay in the top.

Test Plan:
- Reset mid-frame: drop reset_n after 7 of 16 bits -> all outputs 0 immediately; after release, a fresh 0xA5C3 frame yields rx_data=0xA5C3 and one io_strobe.
- Duplex: tx_word=0x1234, HPS sends 0xBEEF -> miso bitstream 0x1234 MSB-first; rx_valid 2 cycles after the final synced edge; gp_out[15:0]=0xBEEF.
- Back-to-back: one cs frame carrying 0x0001, 0x0002, 0x0003 with rx_ready=0 -> three FIFO entries, popped in order, three strobes.
- Overrun: 5 words into FIFO_DEPTH=4 with rx_ready=0 -> fifo_full=1, overrun=1, 5 strobes, 5th word lost. clr_overrun clears the flag; a pop plus push in the same cycle at full sets no overrun.
- Abort: cs rises after 9 bits -> no push, no strobe, last_rx_word unchanged. The next full frame completes normally.
- Enables: hps_en=3'b101 -> gp_out enable field equals 101 after SYNC_STAGES+1 cycles. Sweep WORD_W=8 and SYNC_STAGES=3 with the same checks.

Source files
------------

// File: rtl/hps_bridge_pkg.sv
// hps_bridge_pkg
//   Shared definitions for the second-generation HPS SPI bridge.
//   - eng_state_t : shift engine state encoding
//   - gp_out field positions. The layout is {en_sync, overrun, fifo_full,
//     last_rx_word}, so every offset above the word depends on WORD_W and
//     is provided as a function of it.
package hps_bridge_pkg;

  typedef enum logic {
    ENG_IDLE  = 1'b0,
    ENG_SHIFT = 1'b1
  } eng_state_t;

  // last_rx_word occupies gp_out[LAST_LSB +: WORD_W]
  localparam int LAST_LSB = 0;

  // fifo_full flag position (FULL_BIT)
  function automatic int full_bit(input int word_w);
    return word_w;
  endfunction

  // sticky overrun flag position (OVR_BIT)
  function automatic int ovr_bit(input int word_w);
    return word_w + 1;
  endfunction

  // lowest bit of the synchronised enable field (EN_LSB)
  function automatic int en_lsb(input int word_w);
    return word_w + 2;
  endfunction

endpackage

// File: rtl/hps_spi_shift_engine.sv
// hps_spi_shift_engine
//   SPI mode-0 slave shift engine running entirely in the sys_clk domain.
//   All SPI inputs arrive already synchronised and edge-detected.
// Ports:
//   sys_clk, reset_n     : system clock, async active-low reset
//   sck_rise, sck_fall   : one-cycle pulses from the synchronised SPI clock
//   cs_fall, cs_rise     : one-cycle pulses from the synchronised chip select
//   cs_sync              : synchronised chip select level (active-low)
//   mosi_sync            : synchronised HPS data
//   tx_word              : word returned to the HPS, sampled at each word start
//   rx_word              : last completed received word
//   word_done            : one-cycle pulse when rx_word has been updated
//   spi_miso             : data to the HPS (0 while deselected)
module hps_spi_shift_engine
  import hps_bridge_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              sck_rise,
  input  logic              sck_fall,
  input  logic              cs_fall,
  input  logic              cs_rise,
  input  logic              cs_sync,
  input  logic              mosi_sync,
  input  logic [WORD_W-1:0] tx_word,
  output logic [WORD_W-1:0] rx_word,
  output logic              word_done,
  output logic              spi_miso
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

  eng_state_t        state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [WORD_W-1:0] rx_shift, rx_shift_n;
  logic [WORD_W-1:0] tx_shift, tx_shift_n;
  logic [WORD_W-1:0] rx_word_n;
  logic              word_done_n;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ENG_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_word   <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx_shift  <= rx_shift_n;
      tx_shift  <= tx_shift_n;
      rx_word   <= rx_word_n;
      word_done <= word_done_n;
    end
  end

  // cs edges take priority over clock edges: a deselect abandons the
  // partial word, and a select (including a glitch mid-frame) restarts
  // at bit 0 with a fresh tx_word.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    rx_shift_n  = rx_shift;
    tx_shift_n  = tx_shift;
    rx_word_n   = rx_word;
    word_done_n = 1'b0;

    if (cs_rise) begin
      state_n   = ENG_IDLE;
      bit_cnt_n = '0;
    end else if (cs_fall) begin
      state_n    = ENG_SHIFT;
      bit_cnt_n  = '0;
      rx_shift_n = '0;
      tx_shift_n = tx_word;
    end else if (state == ENG_SHIFT) begin
      if (sck_rise) begin
        rx_shift_n = {rx_shift[WORD_W-2:0], mosi_sync};
        if (bit_cnt == LAST_CNT) begin
          word_done_n = 1'b1;
          rx_word_n   = rx_shift_n;
          bit_cnt_n   = '0;
          tx_shift_n  = tx_word;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end else if (sck_fall && (bit_cnt != '0)) begin
        // The fall right after a word boundary must not shift: tx_shift
        // was just reloaded and its MSB is the next bit the HPS samples.
        tx_shift_n = {tx_shift[WORD_W-2:0], 1'b0};
      end
    end
  end

  assign spi_miso = (state == ENG_SHIFT) && !cs_sync && tx_shift[WORD_W-1];

endmodule

// File: rtl/hps_spi_bridge.sv
// hps_spi_bridge
//   HPS SPI link: synchronises the HPS SPI and enable pins into sys_clk,
//   runs a mode-0 shift engine and queues received words in an RX FIFO.
// Ports:
//   sys_clk, reset_n    : system clock, async active-low reset
//   spi_clk/cs/mosi     : async HPS SPI inputs (clock idle low, cs active-low)
//   spi_miso            : data back to the HPS
//   hps_en              : async HPS enable lines (fpga/osd/io = bits 0/1/2)
//   tx_word             : word returned to the HPS, sampled at each word start
//   rx_data/rx_valid    : FIFO head word / FIFO non-empty
//   rx_ready            : head is popped when rx_valid & rx_ready
//   clr_overrun         : one-cycle pulse clearing the sticky overrun flag
//   io_strobe           : one-cycle pulse per completed word
//   gp_out              : registered {en_sync, overrun, fifo_full, last_rx_word}
module hps_spi_bridge
  import hps_bridge_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int NUM_EN      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     spi_clk,
  input  logic                     spi_cs,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic [NUM_EN-1:0]        hps_en,
  input  logic [WORD_W-1:0]        tx_word,
  output logic [WORD_W-1:0]        rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  input  logic                     clr_overrun,
  output logic                     io_strobe,
  output logic [WORD_W+NUM_EN+1:0] gp_out
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int FULL_B = full_bit(WORD_W);
  localparam int OVR_B  = ovr_bit(WORD_W);
  localparam int EN_L   = en_lsb(WORD_W);

  // Reset asserts asynchronously everywhere but is released through two
  // flops so no register leaves reset close to a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_sync_n;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_sync_n = rst_pipe[1];

  // Input synchronisers plus one extra flop on sck/cs for edge detection.
  // The cs chain resets high so leaving reset never looks like a select.
  logic [SYNC_STAGES-1:0]             sck_chain, cs_chain, mosi_chain;
  logic [SYNC_STAGES-1:0][NUM_EN-1:0] en_chain;
  logic                               sck_d, cs_d;

  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sck_chain  <= '0;
      cs_chain   <= '1;
      mosi_chain <= '0;
      en_chain   <= '0;
      sck_d      <= 1'b0;
      cs_d       <= 1'b1;
    end else begin
      sck_chain  <= {sck_chain[SYNC_STAGES-2:0], spi_clk};
      cs_chain   <= {cs_chain[SYNC_STAGES-2:0], spi_cs};
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
      en_chain   <= {en_chain[SYNC_STAGES-2:0], hps_en};
      sck_d      <= sck_chain[SYNC_STAGES-1];
      cs_d       <= cs_chain[SYNC_STAGES-1];
    end
  end

  logic              sck_sync, cs_sync, mosi_sync;
  logic [NUM_EN-1:0] en_sync;
  logic              sck_rise, sck_fall, cs_fall, cs_rise;

  assign sck_sync  = sck_chain[SYNC_STAGES-1];
  assign cs_sync   = cs_chain[SYNC_STAGES-1];
  assign mosi_sync = mosi_chain[SYNC_STAGES-1];
  assign en_sync   = en_chain[SYNC_STAGES-1];
  assign sck_rise  =  sck_sync & ~sck_d;
  assign sck_fall  = ~sck_sync &  sck_d;
  assign cs_fall   = ~cs_sync  &  cs_d;
  assign cs_rise   =  cs_sync  & ~cs_d;

  logic [WORD_W-1:0] rx_word;
  logic              word_done;

  hps_spi_shift_engine #(
    .WORD_W (WORD_W)
  ) u_engine (
    .sys_clk   (sys_clk),
    .reset_n   (rst_sync_n),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_sync   (cs_sync),
    .mosi_sync (mosi_sync),
    .tx_word   (tx_word),
    .rx_word   (rx_word),
    .word_done (word_done),
    .spi_miso  (spi_miso)
  );

  // RX FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic              fifo_empty, fifo_full, full_n;
  logic              pop, push_ok, drop;
  logic              overrun, overrun_n;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && rx_ready;

  // A full FIFO still takes the word when the head leaves in the same
  // cycle; clearing overrun loses to a simultaneous new drop.
  always_comb begin
    push_ok   = word_done && (!fifo_full || pop);
    drop      = word_done && !push_ok;
    wr_ptr_n  = wr_ptr + (AW+1)'(push_ok);
    rd_ptr_n  = rd_ptr + (AW+1)'(pop);
    full_n    = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    overrun_n = drop || (overrun && !clr_overrun);
  end

  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      overrun <= overrun_n;
    end
  end

  // Storage has no reset; rx_data is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_word;
  end

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Flags are packed from their next-state values so gp_out lines up with
  // rx_valid and io_strobe in the same cycle.
  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      io_strobe <= 1'b0;
      gp_out    <= '0;
    end else begin
      io_strobe                <= word_done;
      gp_out[EN_L +: NUM_EN]   <= en_sync;
      gp_out[OVR_B]            <= overrun_n;
      gp_out[FULL_B]           <= full_n;
      if (word_done) gp_out[LAST_LSB +: WORD_W] <= rx_word;
    end
  end

endmodule

// File: tb/tb_hps_spi_bridge.sv
// tb_hps_spi_bridge
//   Self-checking bench for hps_spi_bridge. A bit-banged HPS master drives
//   frames; expected words go into a scoreboard queue and a monitor pops
//   and compares whenever the DUT hands a word out.
module tb_hps_spi_bridge #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2
);

  localparam int NUM_EN = 3;
  localparam int DEPTH  = 4;
  localparam int HALF   = 8;
  localparam int GP_W   = WORD_W + NUM_EN + 2;

  logic              sys_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              spi_clk = 1'b0;
  logic              spi_cs = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic [NUM_EN-1:0] hps_en = '0;
  logic [WORD_W-1:0] tx_word = '0;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready = 1'b0;
  logic              clr_overrun = 1'b0;
  logic              io_strobe;
  logic [GP_W-1:0]   gp_out;

  hps_spi_bridge #(
    .WORD_W      (WORD_W),
    .NUM_EN      (NUM_EN),
    .SYNC_STAGES (SYNC_STAGES),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .hps_en      (hps_en),
    .tx_word     (tx_word),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .clr_overrun (clr_overrun),
    .io_strobe   (io_strobe),
    .gp_out      (gp_out)
  );

  always #5 sys_clk = ~sys_clk;

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                ready_mode = 0;
  int                done_rise_cyc = 0;
  int                exp_strobes = 0;
  int                seen_strobes = 0;
  int                pops = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] frame_q[$];
  logic [WORD_W-1:0] exp_last = '0;
  logic              exp_ovr = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // rx_ready: 0 = hold low, 1 = hold high, 2 = random back-pressure
  always @(posedge sys_clk) begin
    #2;
    case (ready_mode)
      1:       rx_ready = 1'b1;
      2:       rx_ready = ($urandom_range(0, 3) != 0);
      default: rx_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Monitor: strobe timing/content and scoreboard pops.
  always @(negedge sys_clk) begin
    if (reset_n) begin
      if (io_strobe) begin
        seen_strobes++;
        checkOutput("strobe_latency", cyc - done_rise_cyc, SYNC_STAGES + 2);
        checkOutput("valid_at_strobe", rx_valid, 1);
        checkOutput("gp_last_word", gp_out[WORD_W-1:0], exp_last);
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word", rx_data);
        end else begin
          checkOutput("rx_data", rx_data, exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  // Send frame_q as one cs frame. abort_bits>0 raises cs after that many
  // bits. mode 1: pop in the push cycle of the last word; mode 2: clear
  // overrun in that cycle.
  task automatic applyStimulus(input int abort_bits, input int mode);
    int  nb = 0;
    bit  stop = 0;
    spi_cs = 1'b0;
    for (int w = 0; w < frame_q.size() && !stop; w++) begin
      for (int b = 0; b < WORD_W; b++) begin
        if (abort_bits > 0 && nb == abort_bits) begin
          stop = 1;
          break;
        end
        spi_mosi = frame_q[w][WORD_W-1-b];
        tick(HALF);
        checkOutput("miso_bit", spi_miso, tx_word[WORD_W-1-b]);
        spi_clk = 1'b1;
        nb++;
        if (b == WORD_W - 1) begin
          done_rise_cyc = cyc;
          exp_strobes++;
          exp_last = frame_q[w];
          if (exp_q.size() < DEPTH || (mode == 1 && w == frame_q.size() - 1))
            exp_q.push_back(frame_q[w]);
          else
            exp_ovr = 1'b1;
          if (mode != 0 && w == frame_q.size() - 1) begin
            tick(SYNC_STAGES + 1);
            if (mode == 1) ready_mode = 1;
            else           clr_overrun = 1'b1;
            tick(1);
            ready_mode  = 0;
            clr_overrun = 1'b0;
            tick(HALF - SYNC_STAGES - 2);
          end else begin
            tick(HALF);
          end
        end else begin
          tick(HALF);
        end
        spi_clk = 1'b0;
      end
    end
    tick(HALF);
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    tick(HALF);
    checkOutput("miso_idle", spi_miso, 0);
    tick(2 * HALF);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish within 100000 cycles");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset state
    tick(3);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_io_strobe", io_strobe, 0);
    checkOutput("reset_gp_out", gp_out, 0);
    checkOutput("reset_miso", spi_miso, 0);
    reset_n = 1'b1;
    tick(4);

    // Duplex: 0x1234 out, 0xBEEF in, word left in the FIFO
    $display("[TB] duplex");
    tx_word = WORD_W'(16'h1234);
    frame_q = '{WORD_W'(16'hBEEF)};
    applyStimulus(0, 0);
    checkOutput("duplex_valid", rx_valid, 1);
    checkOutput("duplex_rx_data", rx_data, WORD_W'(16'hBEEF));
    checkOutput("duplex_gp_word", gp_out[WORD_W-1:0], WORD_W'(16'hBEEF));

    // Enables reach gp_out after SYNC_STAGES+1 cycles
    $display("[TB] enables");
    hps_en = 3'b101;
    tick(SYNC_STAGES);
    checkOutput("en_not_yet", gp_out[WORD_W+2 +: NUM_EN], 3'b000);
    tick(1);
    checkOutput("en_field", gp_out[WORD_W+2 +: NUM_EN], 3'b101);

    // Reset mid-frame
    $display("[TB] reset mid-frame");
    tx_word = WORD_W'(16'hFFFF);
    spi_cs  = 1'b0;
    for (int b = 0; b < 7; b++) begin
      spi_mosi = b[0];
      tick(HALF);
      spi_clk = 1'b1;
      tick(HALF);
      spi_clk = 1'b0;
    end
    tick(HALF);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_rx_valid", rx_valid, 0);
    checkOutput("midrst_rx_data", rx_data, 0);
    checkOutput("midrst_gp_out", gp_out, 0);
    checkOutput("midrst_miso", spi_miso, 0);
    spi_cs   = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    exp_q.delete();
    exp_last = '0;
    exp_ovr  = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
    ready_mode = 1;
    frame_q = '{WORD_W'(16'hA5C3)};
    applyStimulus(0, 0);
    checkOutput("after_reset_strobes", seen_strobes, exp_strobes);
    checkOutput("after_reset_gp_word", gp_out[WORD_W-1:0], WORD_W'(16'hA5C3));

    // Back-to-back words in one frame
    $display("[TB] back-to-back");
    ready_mode = 0;
    tick(2);
    frame_q = '{WORD_W'(1), WORD_W'(2), WORD_W'(3)};
    applyStimulus(0, 0);
    checkOutput("b2b_valid", rx_valid, 1);
    checkOutput("b2b_head", rx_data, WORD_W'(1));
    checkOutput("b2b_not_full", gp_out[WORD_W], 0);
    pops = 0;
    ready_mode = 1;
    tick(10);
    checkOutput("b2b_pops", pops, 3);
    checkOutput("b2b_empty", rx_valid, 0);
    checkOutput("b2b_strobes", seen_strobes, exp_strobes);

    // Overrun
    $display("[TB] overrun");
    ready_mode = 0;
    tick(2);
    frame_q.delete();
    for (int i = 0; i < 5; i++) frame_q.push_back(WORD_W'($urandom));
    applyStimulus(0, 0);
    checkOutput("ovr_full", gp_out[WORD_W], 1);
    checkOutput("ovr_flag", gp_out[WORD_W+1], exp_ovr);
    checkOutput("ovr_strobes", seen_strobes, exp_strobes);
    checkOutput("ovr_head", rx_data, frame_q[0]);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    tick(1);
    checkOutput("ovr_cleared", gp_out[WORD_W+1], exp_ovr);
    frame_q = '{WORD_W'($urandom)};
    applyStimulus(0, 2);
    checkOutput("ovr_clear_vs_drop", gp_out[WORD_W+1], exp_ovr);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    tick(1);
    frame_q = '{WORD_W'($urandom)};
    applyStimulus(0, 1);
    checkOutput("ovr_pop_push", gp_out[WORD_W+1], exp_ovr);
    checkOutput("ovr_still_full", gp_out[WORD_W], 1);
    ready_mode = 1;
    tick(10);
    checkOutput("ovr_drained", rx_valid, 0);
    checkOutput("ovr_full_clear", gp_out[WORD_W], 0);

    // Abort after 9 bits, then a normal frame
    $display("[TB] abort");
    tx_word = WORD_W'($urandom);
    frame_q = '{WORD_W'($urandom), WORD_W'($urandom)};
    applyStimulus(9, 0);
    checkOutput("abort_strobes", seen_strobes, exp_strobes);
    checkOutput("abort_last_word", gp_out[WORD_W-1:0], exp_last);
    frame_q = '{WORD_W'($urandom)};
    applyStimulus(0, 0);
    checkOutput("post_abort_strobes", seen_strobes, exp_strobes);

    // Random traffic with random back-pressure
    $display("[TB] random");
    ready_mode = 2;
    for (int f = 0; f < 20; f++) begin
      tx_word = WORD_W'($urandom);
      frame_q.delete();
      for (int i = 0; i < $urandom_range(1, 3); i++)
        frame_q.push_back(WORD_W'($urandom));
      applyStimulus(0, 0);
    end
    ready_mode = 1;
    tick(20);
    checkOutput("final_queue_left", exp_q.size(), 0);
    checkOutput("final_strobes", seen_strobes, exp_strobes);
    checkOutput("final_overrun", gp_out[WORD_W+1], exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
